// File: rtl/dual_button_debouncer.sv
// -----------------------------------------------------------------------------
// dual_button_debouncer
//
// Two independent debouncers for the raw board pushbuttons. Their clean levels
// drive the xor2 gate's x0/x1 inputs, and each channel also gives a one-cycle
// strobe when its level goes 0->1, for downstream counters and LEDs.
//
// Each channel has three parts:
//   - a two-flop synchroniser on the raw input
//   - a two-state filter FSM
//   - a stability counter
// A new level is accepted only after the synchronised input has disagreed
// with the current output for DEBOUNCE_CYCLES+1 consecutive cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES  mismatch cycles counted in CHECK before acceptance (>= 2)
//   CNT_W            counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports:
//   clk       in   system clock (12 MHz on board)
//   rst_n     in   asynchronous active-low reset
//   sw0, sw1  in   raw, bouncy, asynchronous button inputs
//   x0, x1    out  debounced levels (registered)
//   x0_pulse  out  one-cycle strobe on x0 rising (registered)
//   x1_pulse  out  one-cycle strobe on x1 rising (registered)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// dual_button_debouncer_chan
//
// One debouncer channel: synchroniser, filter FSM and stability counter.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_sw        raw button input
//   o_level     debounced level
//   o_pulse     one-cycle strobe on o_level rising
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_STABLE | synchronised input agrees with o_level; counter held at 0
// ST_CHECK  | input disagrees; counting consecutive mismatch cycles
// -----------------------------------------------------------------------------
module dual_button_debouncer_chan #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  output logic o_level,
  output logic o_pulse
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_pulse;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_level_nxt;
  logic             w_pulse_nxt;
  logic             w_mismatch;

  // i_sw is asynchronous to clk; only r_sync2 is used past this point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_mismatch = (r_sync2 != r_level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_level_nxt = r_level;
    w_pulse_nxt = 1'b0;

    case (r_state)
      ST_STABLE: begin
        if (w_mismatch) begin
          w_state_nxt = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (!w_mismatch) begin
          // Bounced back before qualifying: drop the pending change silently.
          w_state_nxt = ST_STABLE;
        end else if (r_cnt == CNT_MAX) begin
          // Accepting a mismatch means the level flips. The new level is 1
          // only when this is a rising edge, so it doubles as the strobe.
          w_state_nxt = ST_STABLE;
          w_level_nxt = r_sync2;
          w_pulse_nxt = r_sync2;
        end else begin
          // Saturates at CNT_MAX because acceptance leaves CHECK.
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_STABLE;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;

endmodule

module dual_button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw0,
  input  logic sw1,
  output logic x0,
  output logic x1,
  output logic x0_pulse,
  output logic x1_pulse
);

  // Catch bad parameterisation at elaboration rather than in silicon.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("dual_button_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end
  if ((DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_width
    $error("dual_button_debouncer: CNT_W too narrow for DEBOUNCE_CYCLES-1");
  end

  // The channels share nothing but clock and reset.
  dual_button_debouncer_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sw    (sw0),
    .o_level (x0),
    .o_pulse (x0_pulse)
  );

  dual_button_debouncer_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sw    (sw1),
    .o_level (x1),
    .o_pulse (x1_pulse)
  );

endmodule
